// File: rtl/fadd_d_arb.sv
// fadd_d_arb: two-requester round-robin front end for a shared double-precision
// adder. Accepts one request at a time, checks that the opcode is one-hot,
// issues it to the adder, waits (bounded) for completion and holds the
// response for the owning requester until that requester accepts it.
module fadd_d_arb #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  // request side
  input  logic [1:0]  i_req_valid,
  output logic [1:0]  o_req_ready,
  input  logic [6:0]  i_req_op0,
  input  logic [6:0]  i_req_op1,
  input  logic [63:0] i_req_a0,
  input  logic [63:0] i_req_b0,
  input  logic [63:0] i_req_a1,
  input  logic [63:0] i_req_b1,
  // response side
  output logic [1:0]  o_resp_valid,
  input  logic [1:0]  i_resp_ready,
  output logic [63:0] o_resp_res,
  output logic        o_resp_illegal_op,
  output logic        o_resp_overflow,
  output logic        o_resp_timeout,
  // adder side
  output logic        o_fadd_ena,
  output logic        o_fadd_add,
  output logic        o_fadd_sub,
  output logic        o_fadd_eq,
  output logic        o_fadd_lt,
  output logic        o_fadd_le,
  output logic        o_fadd_max,
  output logic        o_fadd_min,
  output logic [63:0] o_fadd_a,
  output logic [63:0] o_fadd_b,
  input  logic        i_fadd_busy,
  input  logic        i_fadd_valid,
  input  logic [63:0] i_fadd_res,
  input  logic        i_fadd_illegal_op,
  input  logic        i_fadd_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [63:0] a;
    logic [63:0] b;
  } req_t;

  typedef struct packed {
    logic [63:0] res;
    logic        ill;
    logic        ovf;
    logic        tmo;
  } rsp_t;

  // WAIT counts up from 0; the step that makes it reach TIMEOUT is the last
  // WAIT cycle, so the response lands exactly TIMEOUT cycles after entry.
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       owner_q, owner_d;
  req_t       req_q, req_d;
  rsp_t       rsp_q, rsp_d;
  logic [3:0] cnt_q, cnt_d;

  logic       win;
  logic       accept;
  req_t       cand;
  logic [1:0] ready;

  // Round-robin pick: the pointer side wins whenever it is requesting.
  always_comb begin
    win      = i_req_valid[ptr_q] ? ptr_q : ~ptr_q;
    cand.op  = win ? i_req_op1 : i_req_op0;
    cand.a   = win ? i_req_a1  : i_req_a0;
    cand.b   = win ? i_req_b1  : i_req_b0;
    accept   = (state_q == S_IDLE) && (|i_req_valid) && !i_fadd_busy;
  end

  // Next-state, latches and accept strobe.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    ready   = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ready[win] = 1'b1;
          owner_d    = win;
          req_d      = cand;
          if ($onehot(cand.op)) begin
            state_d = S_ISSUE;
          end else begin
            // malformed opcode never reaches the adder
            rsp_d.res = '0;
            rsp_d.ill = 1'b1;
            rsp_d.ovf = 1'b0;
            rsp_d.tmo = 1'b0;
            state_d   = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a result in the final cycle beats the timeout
        if (i_fadd_valid) begin
          rsp_d.res = i_fadd_res;
          rsp_d.ill = i_fadd_illegal_op;
          rsp_d.ovf = i_fadd_overflow;
          rsp_d.tmo = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == TMO_LAST) begin
            rsp_d.res = '0;
            rsp_d.ill = 1'b0;
            rsp_d.ovf = 1'b0;
            rsp_d.tmo = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: begin
        // only the owner's ready completes the handshake
        if (i_resp_ready[owner_q]) begin
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      req_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs: accept strobe is combinational, so it is masked while in reset.
  always_comb begin
    o_req_ready       = ready & {2{i_nrst}};
    o_resp_valid      = (state_q == S_RESP) ? (2'b01 << owner_q) : 2'b00;
    o_resp_res        = rsp_q.res;
    o_resp_illegal_op = rsp_q.ill;
    o_resp_overflow   = rsp_q.ovf;
    o_resp_timeout    = rsp_q.tmo;
    o_fadd_ena        = (state_q == S_ISSUE);
    o_fadd_add        = o_fadd_ena & req_q.op[0];
    o_fadd_sub        = o_fadd_ena & req_q.op[1];
    o_fadd_eq         = o_fadd_ena & req_q.op[2];
    o_fadd_lt         = o_fadd_ena & req_q.op[3];
    o_fadd_le         = o_fadd_ena & req_q.op[4];
    o_fadd_max        = o_fadd_ena & req_q.op[5];
    o_fadd_min        = o_fadd_ena & req_q.op[6];
    o_fadd_a          = req_q.a;
    o_fadd_b          = req_q.b;
  end

endmodule

// File: tb/tb_fadd_d_arb.sv
// Self-checking bench for fadd_d_arb: directed scenarios plus randomized
// transactions against a transaction-level reference (round-robin pointer,
// one-hot legality, latency = min(adder latency, TIMEOUT) + 1 after issue).
module tb_fadd_d_arb;
  localparam int TMO = 15;

  logic        i_clk, i_nrst;
  logic [1:0]  i_req_valid, o_req_ready;
  logic [6:0]  i_req_op0, i_req_op1;
  logic [63:0] i_req_a0, i_req_b0, i_req_a1, i_req_b1;
  logic [1:0]  o_resp_valid, i_resp_ready;
  logic [63:0] o_resp_res;
  logic        o_resp_illegal_op, o_resp_overflow, o_resp_timeout;
  logic        o_fadd_ena, o_fadd_add, o_fadd_sub, o_fadd_eq, o_fadd_lt;
  logic        o_fadd_le, o_fadd_max, o_fadd_min;
  logic [63:0] o_fadd_a, o_fadd_b;
  logic        i_fadd_busy, i_fadd_valid;
  logic [63:0] i_fadd_res;
  logic        i_fadd_illegal_op, i_fadd_overflow;

  int checks = 0;
  int fails  = 0;
  int ptr    = 0;   // model of the round-robin pointer

  logic       any_out;
  logic [6:0] sel;
  assign any_out = |{o_req_ready, o_resp_valid, o_resp_res, o_resp_illegal_op,
                     o_resp_overflow, o_resp_timeout, o_fadd_ena, sel,
                     o_fadd_a, o_fadd_b};
  assign sel = {o_fadd_min, o_fadd_max, o_fadd_le, o_fadd_lt, o_fadd_eq,
                o_fadd_sub, o_fadd_add};

  fadd_d_arb #(.TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op0(i_req_op0), .i_req_op1(i_req_op1),
    .i_req_a0(i_req_a0), .i_req_b0(i_req_b0),
    .i_req_a1(i_req_a1), .i_req_b1(i_req_b1),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_res(o_resp_res), .o_resp_illegal_op(o_resp_illegal_op),
    .o_resp_overflow(o_resp_overflow), .o_resp_timeout(o_resp_timeout),
    .o_fadd_ena(o_fadd_ena), .o_fadd_add(o_fadd_add), .o_fadd_sub(o_fadd_sub),
    .o_fadd_eq(o_fadd_eq), .o_fadd_lt(o_fadd_lt), .o_fadd_le(o_fadd_le),
    .o_fadd_max(o_fadd_max), .o_fadd_min(o_fadd_min),
    .o_fadd_a(o_fadd_a), .o_fadd_b(o_fadd_b),
    .i_fadd_busy(i_fadd_busy), .i_fadd_valid(i_fadd_valid),
    .i_fadd_res(i_fadd_res), .i_fadd_illegal_op(i_fadd_illegal_op),
    .i_fadd_overflow(i_fadd_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] rnd_op();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 7'h00;
    if (r == 1) return 7'h03 | 7'($urandom);
    return 7'(1 << $urandom_range(0, 6));
  endfunction

  // One full transaction, entered and left on a falling edge.
  // lat: cycles from the issue cycle to the adder's valid pulse.
  task automatic txn(input logic [1:0] mask, input int busy_n, input int lat, input int bp,
                     input logic [6:0] op0, input logic [6:0] op1,
                     input logic [63:0] a0, input logic [63:0] b0,
                     input logic [63:0] a1, input logic [63:0] b1,
                     input logic [63:0] fres, input logic fill, input logic fovf);
    int w, k, e_k, bad;
    logic [6:0] wop;
    logic [63:0] wa, wb, e_res;
    logic e_ill, e_ovf, e_tmo, legal;

    w   = mask[ptr] ? ptr : 1 - ptr;
    wop = (w == 1) ? op1 : op0;
    wa  = (w == 1) ? a1 : a0;
    wb  = (w == 1) ? b1 : b0;
    legal = ($countones(wop) == 1);

    i_req_op0 = op0; i_req_op1 = op1;
    i_req_a0 = a0; i_req_b0 = b0; i_req_a1 = a1; i_req_b1 = b1;
    i_req_valid = mask;
    for (int c = 0; c < busy_n; c++) begin
      i_fadd_busy = 1'b1;
      #1 chk("busy_rdy", 64'(o_req_ready), 64'd0);
      @(negedge i_clk);
    end
    i_fadd_busy = 1'b0;
    #1 chk("rdy", 64'(o_req_ready), 64'(2'b01 << w));
    @(negedge i_clk);
    i_req_valid = 2'b00;

    if (!legal) begin
      e_res = '0; e_ill = 1'b1; e_ovf = 1'b0; e_tmo = 1'b0;
      chk("ill_noena", 64'(o_fadd_ena), 64'd0);
    end else begin
      chk("ena", 64'(o_fadd_ena), 64'd1);
      chk("ops", 64'(sel), 64'(wop));
      chk("opa", o_fadd_a, wa);
      chk("opb", o_fadd_b, wb);
      if (lat <= TMO) begin
        e_res = fres; e_ill = fill; e_ovf = fovf; e_tmo = 1'b0; e_k = lat + 1;
      end else begin
        e_res = '0; e_ill = 1'b0; e_ovf = 1'b0; e_tmo = 1'b1; e_k = TMO + 1;
      end
      bad = 0;
      for (k = 1; k <= 40; k++) begin
        @(negedge i_clk);
        if (k == 1) chk("ena_pulse", 64'(o_fadd_ena), 64'd0);
        if (o_resp_valid != 2'b00) break;
        if (o_fadd_a !== wa || o_fadd_b !== wb) bad++;
        i_fadd_valid = (k == lat);
        i_fadd_res = fres; i_fadd_illegal_op = fill; i_fadd_overflow = fovf;
      end
      i_fadd_valid = 1'b0;
      chk("opnd_hold", 64'(bad), 64'd0);
      chk("latency", 64'(k), 64'(e_k));
    end

    chk("rvld", 64'(o_resp_valid), 64'(2'b01 << w));
    chk("rres", o_resp_res, e_res);
    chk("rflags", 64'({o_resp_illegal_op, o_resp_overflow, o_resp_timeout}),
        64'({e_ill, e_ovf, e_tmo}));

    // backpressure: only the non-owner is ready, plus a stray adder pulse
    i_resp_ready = ~(2'b01 << w);
    bad = 0;
    for (int c = 0; c < bp; c++) begin
      i_fadd_valid = (c == 1);
      i_fadd_res = ~e_res; i_fadd_illegal_op = ~e_ill; i_fadd_overflow = ~e_ovf;
      @(negedge i_clk);
      if (o_resp_valid !== (2'b01 << w) || o_resp_res !== e_res ||
          {o_resp_illegal_op, o_resp_overflow, o_resp_timeout} !== {e_ill, e_ovf, e_tmo})
        bad++;
    end
    i_fadd_valid = 1'b0;
    chk("resp_hold", 64'(bad), 64'd0);

    // completion cycle: nothing may be accepted while still in RESP
    i_resp_ready = 2'b11;
    i_req_valid  = 2'b11;
    #1 chk("no_acc_resp", 64'(o_req_ready), 64'd0);
    @(negedge i_clk);
    i_resp_ready = 2'b00;
    i_req_valid  = 2'b00;
    chk("done", 64'(o_resp_valid), 64'd0);
    ptr = 1 - w;
  endtask

  initial begin
    logic [63:0] r0, r1;
    i_nrst = 1'b0; i_req_valid = '0; i_req_op0 = '0; i_req_op1 = '0;
    i_req_a0 = '0; i_req_b0 = '0; i_req_a1 = '0; i_req_b1 = '0;
    i_resp_ready = '0; i_fadd_busy = 1'b0; i_fadd_valid = 1'b0;
    i_fadd_res = '0; i_fadd_illegal_op = 1'b0; i_fadd_overflow = 1'b0;

    // reset: outputs quiet even with requests and adder activity present
    @(negedge i_clk);
    i_req_valid = 2'b11; i_fadd_valid = 1'b1;
    #1 chk("rst_quiet", 64'(any_out), 64'd0);
    @(negedge i_clk);
    i_nrst = 1'b1; i_req_valid = '0; i_fadd_valid = 1'b0; ptr = 0;

    // single add
    txn(2'b01, 0, 6, 0, 7'h01, 7'h00, 64'h3FF0000000000000, 64'h4000000000000000,
        64'd0, 64'd0, 64'h4008000000000000, 1'b0, 1'b0);
    // contention from a fresh pointer: alternates
    for (int t = 0; t < 4; t++)
      txn(2'b11, 0, 2 + t, 0, 7'h02, 7'h04, 64'(t), 64'(t + 10), 64'(t + 20),
          64'(t + 30), {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    // illegal opcode
    txn(2'b01, 0, 3, 0, 7'h03, 7'h01, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 1'b0, 1'b0);
    // timeout: adder never answers
    txn(2'b10, 0, 99, 0, 7'h01, 7'h40, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5, 1'b0, 1'b0);
    // result in the last WAIT cycle beats the timeout
    txn(2'b01, 0, TMO, 0, 7'h10, 7'h01, 64'h7, 64'h8, 64'h9, 64'hA,
        64'hC0FFEE, 1'b0, 1'b1);
    // backpressure with stray adder pulse
    txn(2'b11, 0, 4, 10, 7'h20, 7'h08, 64'h11, 64'h12, 64'h13, 64'h14,
        64'hDEADBEEF, 1'b1, 1'b0);
    // adder busy holds off acceptance
    txn(2'b01, 3, 2, 0, 7'h01, 7'h01, 64'h21, 64'h22, 64'h23, 64'h24,
        64'h25, 1'b0, 1'b0);

    // reset in the middle of WAIT
    i_req_op0 = 7'h01; i_req_a0 = 64'h55; i_req_b0 = 64'h66; i_req_valid = 2'b01;
    #1 chk("rm_rdy", 64'(o_req_ready), 64'd1);
    @(negedge i_clk);
    i_req_valid = 2'b00;
    chk("rm_ena", 64'(o_fadd_ena), 64'd1);
    repeat (3) @(negedge i_clk);
    i_req_valid = 2'b11; i_nrst = 1'b0;
    #1 chk("rm_out", 64'(any_out), 64'd0);
    @(negedge i_clk);
    i_req_valid = 2'b00;
    @(negedge i_clk);
    i_nrst = 1'b1; ptr = 0;
    txn(2'b10, 0, 3, 2, 7'h00, 7'h02, 64'h1, 64'h2, 64'h3, 64'h4,
        64'h1234, 1'b0, 1'b0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 2),
          ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(1, TMO + 1),
          $urandom_range(0, 4), rnd_op(), rnd_op(), r0, r1, ~r0, ~r1,
          {$urandom, $urandom}, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
